// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read address/data channel between icache and dcache.
// One read is in flight at a time, and the returned beats are steered to the cache that won the grant.
module cache_rd_arbiter #(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [3:0]  INST_ID    = 4'd0,
  parameter logic [3:0]  DATA_ID    = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_rd_req,
  input  logic        inst_rd_type,
  input  logic [31:0] inst_rd_addr,
  output logic        inst_rd_rdy,
  output logic        inst_ret_valid,
  output logic        inst_ret_last,
  input  logic        data_rd_req,
  input  logic        data_rd_type,
  input  logic [31:0] data_rd_addr,
  output logic        data_rd_rdy,
  output logic        data_ret_valid,
  output logic        data_ret_last,
  output logic [31:0] ret_data,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned CW = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t        state_reg, state_next;
  logic          grant_reg, grant_next;          // 1 = dcache owns the transfer
  logic          last_grant_reg, last_grant_next;
  logic [3:0]    arid_reg, arid_next;
  logic [31:0]   araddr_reg, araddr_next;
  logic [7:0]    arlen_reg, arlen_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic ar_hs;
  logic beat;
  logic last_beat;
  logic pick_data;

  assign ar_hs     = (state_reg == AR) && arready;
  assign beat      = (state_reg == R) && rvalid;
  assign last_beat = beat && ({{(8-CW){1'b0}}, cnt_reg} == arlen_reg);

  // dcache wins when it is the only requester, or when both request and icache had the previous grant.
  assign pick_data = data_rd_req && (!inst_rd_req || !last_grant_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      arid_reg       <= 4'd0;
      araddr_reg     <= 32'd0;
      arlen_reg      <= 8'd0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      arid_reg       <= arid_next;
      araddr_reg     <= araddr_next;
      arlen_reg      <= arlen_next;
      cnt_reg        <= cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    arid_next       = arid_reg;
    araddr_next     = araddr_reg;
    arlen_next      = arlen_reg;
    cnt_next        = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (inst_rd_req || data_rd_req) begin
          grant_next      = pick_data;
          last_grant_next = pick_data;
          arid_next       = pick_data ? DATA_ID : INST_ID;
          araddr_next     = pick_data ? data_rd_addr : inst_rd_addr;
          arlen_next      = (pick_data ? data_rd_type : inst_rd_type) ? 8'(LINE_WORDS - 1) : 8'd0;
          state_next      = AR;
        end
      end
      AR: begin
        if (arready) begin
          cnt_next   = '0;
          state_next = R;
        end
      end
      R: begin
        if (rvalid) begin
          cnt_next = cnt_reg + CW'(1);
          if (last_beat) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign arvalid        = (state_reg == AR);
  assign rready         = (state_reg == R);
  assign arid           = arid_reg;
  assign araddr         = araddr_reg;
  assign arlen          = arlen_reg;
  assign arsize         = 3'b010;
  assign inst_rd_rdy    = ar_hs && !grant_reg;
  assign data_rd_rdy    = ar_hs && grant_reg;
  assign inst_ret_valid = beat && !grant_reg;
  assign data_ret_valid = beat && grant_reg;
  assign inst_ret_last  = last_beat && !grant_reg;
  assign data_ret_last  = last_beat && grant_reg;
  assign ret_data       = rdata;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Scoreboard bench for cache_rd_arbiter: a transaction-level arbitration model predicts AR requests and beats,
// and a negedge monitor checks them against what the DUT presents.
module tb_cache_rd_arbiter;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_rd_req, inst_rd_type, data_rd_req, data_rd_type;
  logic [31:0] inst_rd_addr, data_rd_addr;
  logic        inst_rd_rdy, inst_ret_valid, inst_ret_last;
  logic        data_rd_rdy, data_ret_valid, data_ret_last;
  logic [31:0] ret_data, araddr, rdata;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid, arready, rvalid, rready;

  cache_rd_arbiter #(.LINE_WORDS(LW), .INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
    .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
    .ret_data(ret_data), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic is_data; logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic is_data; logic [31:0] data; logic last; } beat_t;

  ar_t   exp_ar_q[$];
  beat_t exp_beat_q[$];
  ar_t   burst_q[$];
  int    rv_pat[$];
  int    checks = 0;
  int    errors = 0;
  int    beat_idx = 0;
  int    ar_wait = 0;
  int    next_ar_wait = 0;
  bit    inst_acc, data_acc;
  bit    mon_en = 1'b1;
  bit    last_data = 1'b0;
  bit    stall_pending = 1'b0;
  logic [43:0] stall_val;

  function automatic logic [31:0] beat_data(logic [31:0] addr, int i);
    return addr ^ (32'h9E3779B9 * (i + 1));
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    ar_t   e;
    beat_t b;
    if (mon_en && !reset) begin
      if (inst_ret_valid || data_ret_valid) begin
        if (exp_beat_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          b = exp_beat_q.pop_front();
          chk("beat_dest", data_ret_valid, b.is_data);
          chk("beat_excl", inst_ret_valid && data_ret_valid, 0);
          chk("beat_data", ret_data, b.data);
          chk("beat_last", inst_ret_last | data_ret_last, b.last);
          $display("beat dest=%0d data=%08h last=%0d", data_ret_valid, ret_data, inst_ret_last | data_ret_last);
        end
      end
      if (rvalid && rready) begin
        if (!(inst_ret_valid || data_ret_valid)) chk("beat_missing", 0, 1);
        if (burst_q.size() > 0) begin
          beat_idx++;
          if (beat_idx > int'(burst_q[0].len)) begin
            void'(burst_q.pop_front());
            beat_idx = 0;
          end
        end
      end
      if ((inst_rd_rdy || data_rd_rdy) && !(arvalid && arready)) chk("rdy_spurious", 1, 0);
      if (arvalid) begin
        if (stall_pending) chk("ar_stable", {arid, araddr, arlen}, stall_val);
        if (arready) begin
          stall_pending = 1'b0;
          if (exp_ar_q.size() == 0) chk("unexpected_ar", 1, 0);
          else begin
            e = exp_ar_q.pop_front();
            chk("arid", arid, e.id);
            chk("araddr", araddr, e.addr);
            chk("arlen", arlen, e.len);
            chk("arsize", arsize, 3'b010);
            chk("inst_rd_rdy", inst_rd_rdy, !e.is_data);
            chk("data_rd_rdy", data_rd_rdy, e.is_data);
            $display("AR id=%0d addr=%08h len=%0d", arid, araddr, arlen);
          end
          burst_q.push_back('{is_data: 1'b0, id: arid, addr: araddr, len: arlen});
          inst_acc |= inst_rd_rdy;
          data_acc |= data_rd_rdy;
          ar_wait = next_ar_wait;
        end else begin
          stall_pending = 1'b1;
          stall_val = {arid, araddr, arlen};
        end
      end
    end
  end

  // AXI AR slave: holds arready low for ar_wait cycles of arvalid
  initial begin
    arready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (arvalid && ar_wait > 0) begin
        arready = 1'b0;
        ar_wait--;
      end else arready = arvalid;
    end
  end

  // AXI R slave: junk rvalid while not in a burst, patterned/random gaps inside one
  initial begin
    rvalid = 1'b0;
    rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (rready && burst_q.size() > 0) begin
        if (rv_pat.size() > 0) rvalid = (rv_pat.pop_front() != 0);
        else rvalid = ($urandom_range(0, 3) != 0);
        rdata = beat_data(burst_q[0].addr, beat_idx);
      end else begin
        rvalid = 1'($urandom_range(0, 1));
        rdata  = $urandom;
      end
    end
  end

  task automatic expect_xfer(bit is_data, logic [31:0] addr, logic typ);
    logic [7:0] len;
    len = typ ? 8'(LW - 1) : 8'd0;
    exp_ar_q.push_back('{is_data: is_data, id: is_data ? 4'd1 : 4'd0, addr: addr, len: len});
    for (int i = 0; i <= int'(len); i++)
      exp_beat_q.push_back('{is_data: is_data, data: beat_data(addr, i), last: (i == int'(len))});
    last_data = is_data;
  endtask

  // kind: 1 = icache only, 2 = dcache only, 3 = both in the same cycle
  task automatic run_round(int kind, logic [31:0] ia, logic it, logic [31:0] da, logic dt, int arw);
    bit first;
    bit done;
    if (kind == 1) expect_xfer(1'b0, ia, it);
    else if (kind == 2) expect_xfer(1'b1, da, dt);
    else begin
      first = !last_data;
      expect_xfer(first, first ? da : ia, first ? dt : it);
      expect_xfer(!first, first ? ia : da, first ? it : dt);
    end
    next_ar_wait = arw;
    @(posedge clk); #1;
    ar_wait      = arw;
    inst_acc     = 1'b0;
    data_acc     = 1'b0;
    inst_rd_req  = kind[0];
    inst_rd_type = it;
    inst_rd_addr = ia;
    data_rd_req  = kind[1];
    data_rd_type = dt;
    data_rd_addr = da;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (inst_acc) inst_rd_req = 1'b0;
      if (data_acc) data_rd_req = 1'b0;
      if (!inst_rd_req && !data_rd_req && exp_beat_q.size() == 0 && exp_ar_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk("round_timeout", 0, 1);
      exp_ar_q.delete();
      exp_beat_q.delete();
      inst_rd_req = 1'b0;
      data_rd_req = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_rd_rdy"}, {inst_rd_rdy, data_rd_rdy}, 0);
    chk({tag, "_ret_valid"}, {inst_ret_valid, data_ret_valid}, 0);
    chk({tag, "_ret_last"}, {inst_ret_last, data_ret_last}, 0);
    chk({tag, "_arid"}, arid, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_arlen"}, arlen, 0);
  endtask

  initial begin : stim
    logic [31:0] ia, da;
    bit waited;
    reset = 1'b1;
    inst_rd_req = 1'b0; inst_rd_type = 1'b0; inst_rd_addr = 32'd0;
    data_rd_req = 1'b0; data_rd_type = 1'b0; data_rd_addr = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    run_round(3, 32'h1C000080, 1'b1, 32'h00001000, 1'b1, 0);  // fresh reset: dcache first
    run_round(1, 32'h1C000040, 1'b1, 32'h0, 1'b0, 0);
    run_round(2, 32'h0, 1'b0, 32'hBFAF8000, 1'b0, 0);
    run_round(1, 32'h1C000100, 1'b1, 32'h0, 1'b0, 5);
    rv_pat = {1, 0, 0, 1, 1, 0, 1};
    run_round(2, 32'h0, 1'b0, 32'h80002000, 1'b1, 0);

    for (int r = 0; r < 40; r++) begin
      ia = $urandom;
      da = $urandom;
      run_round($urandom_range(1, 3), ia & ~32'(LW * 4 - 1), 1'($urandom_range(0, 1)),
                da & ~32'(LW * 4 - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset while the second beat of a line is in flight
    rv_pat = {1, 1, 1, 1};
    expect_xfer(1'b0, 32'h1C000200, 1'b1);
    next_ar_wait = 0;
    @(posedge clk); #1;
    ar_wait = 0;
    inst_acc = 1'b0;
    inst_rd_req = 1'b1; inst_rd_type = 1'b1; inst_rd_addr = 32'h1C000200;
    waited = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (inst_acc) inst_rd_req = 1'b0;
      if (beat_idx >= 1) begin
        waited = 1'b1;
        break;
      end
    end
    if (!waited) chk("reset_test_timeout", 0, 1);
    reset = 1'b1;
    mon_en = 1'b0;
    inst_rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_ar_q.delete();
    exp_beat_q.delete();
    burst_q.delete();
    rv_pat.delete();
    beat_idx = 0;
    stall_pending = 1'b0;
    last_data = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    run_round(3, 32'h1C000300, 1'b0, 32'h00004000, 1'b1, 1);  // last grant restored to icache

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
